// File: rtl/main_mem_ctrl.sv
// Main memory model behind the cache controller: 64-byte block reads and
// single-word writes, each completing after a fixed LATENCY.
module main_mem_ctrl #(
  parameter int unsigned LATENCY      = 4,
  parameter int unsigned DEPTH_BLOCKS = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  main_mem_addr,
  input  logic [31:0]  main_mem_data_out,
  input  logic         main_mem_read_req,
  input  logic         main_mem_write_req,
  output logic [511:0] main_mem_data_in,
  output logic         main_mem_ready,
  output logic         mem_busy,
  output logic         protocol_err
);

  localparam int unsigned IDX_W = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [7:0]       cnt;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       word_q;
  logic [31:0]      wdata_q;
  logic             op_wr_q;
  logic             drop;
  logic [IDX_W-1:0] idx_d;
  logic             unused_addr_bits;

  logic [511:0] store [DEPTH_BLOCKS];

  assign idx_d            = main_mem_addr[IDX_W+5:6];
  assign unused_addr_bits = ^{main_mem_addr[1:0], main_mem_addr[31:IDX_W+6]};

  assign main_mem_ready = (state == RESP);
  assign mem_busy       = (state != IDLE);

  // In IDLE only a read+write collision drops; elsewhere any request drops.
  always_comb begin
    drop = 1'b0;
    if (state == IDLE) drop = main_mem_read_req & main_mem_write_req;
    else               drop = main_mem_read_req | main_mem_write_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      idx_q            <= '0;
      word_q           <= '0;
      wdata_q          <= '0;
      op_wr_q          <= 1'b0;
      main_mem_data_in <= '0;
      protocol_err     <= 1'b0;
    end else begin
      protocol_err <= drop;
      case (state)
        IDLE: begin
          if (main_mem_read_req || main_mem_write_req) begin
            state   <= BUSY;
            cnt     <= LAT_M1;
            idx_q   <= idx_d;
            word_q  <= main_mem_addr[5:2];
            wdata_q <= main_mem_data_out;
            op_wr_q <= ~main_mem_read_req;
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            state <= RESP;
            if (!op_wr_q) main_mem_data_in <= store[idx_q];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Commit happens on the RESP-to-IDLE edge; a reset forces IDLE first, so an
  // interrupted write never reaches the store.
  always_ff @(posedge clk) begin
    if (state == RESP && op_wr_q)
      store[idx_q][{word_q, 5'b0} +: 32] <= wdata_q;
  end

endmodule
